// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: constants, fetch-state
// encoding, the output record type and the redirect-priority helper.
package instr_fetch_stage_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } fetch_out_t;

    localparam fetch_out_t BUBBLE = '{pc4: 32'h0, inst: NOP_INST, valid: 1'b0};

    // Jump outranks a simultaneous taken branch.
    function automatic logic [31:0] redirect_target(
        input logic        jump,
        input logic [31:0] jump_addr,
        input logic [31:0] brench_addr
    );
        return jump ? jump_addr : brench_addr;
    endfunction

endpackage

// File: rtl/instr_fetch_stage_fetch_hold_buf.sv
// Capture/release buffer for an instruction ({pc+4, inst}) fetched while the
// downstream stage is stalled.
module fetch_hold_buf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic        rel,
    input  logic        clear,
    input  logic [63:0] din,
    output logic [63:0] dout
);

    // NOTE: this is a single register, not a memory array, so it is cheap to
    // reset and doing so keeps a dropped instruction from lingering.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end else if (rel) begin
            dout <= '0;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the req/ack instruction-memory
// port, applies jump/branch redirects and hazard stalls, feeds IF_ID.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Hazard_stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        brench_i,
    input  logic [31:0] brench_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] addedPC_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    fetch_state_e state;
    fetch_out_t   out_q;
    logic [31:0]  pc;
    logic [31:0]  redir_tgt;
    logic [31:0]  pc_plus4;
    logic [31:0]  tgt;
    logic         redirect;
    logic         buf_load;
    logic         buf_rel;
    logic         buf_clear;
    logic [63:0]  hold_data;

    assign redirect = jump_i | brench_i;
    assign tgt      = redirect_target(jump_i, jump_addr_i, brench_addr_i);
    assign pc_plus4 = pc + PC_STEP;

    assign imem_req_o  = ((state == FETCH) || (state == DRAIN)) && !rst_i;
    assign imem_addr_o = pc;

    assign addedPC_o = out_q.pc4;
    assign inst_o    = out_q.inst;
    assign valid_o   = out_q.valid;

    assign buf_load  = (state == FETCH) && imem_ack_i && !redirect && Hazard_stall_i;
    assign buf_rel   = (state == HOLD) && !redirect && !Hazard_stall_i;
    assign buf_clear = (state == HOLD) && redirect;

    fetch_hold_buf u_hold_buf (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (buf_load),
        .rel   (buf_rel),
        .clear (buf_clear),
        .din   ({pc_plus4, imem_data_i}),
        .dout  (hold_data)
    );

    // Outputs not assigned in a branch keep their value, which is the stall hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            redir_tgt <= 32'h0;
            out_q     <= BUBBLE;
        end else begin
            unique case (state)
                FETCH: begin
                    if (redirect) begin
                        out_q <= BUBBLE;
                        if (imem_ack_i) begin
                            pc <= tgt;
                        end else begin
                            redir_tgt <= tgt;
                            state     <= DRAIN;
                        end
                    end else if (imem_ack_i) begin
                        if (Hazard_stall_i) begin
                            state <= HOLD;
                        end else begin
                            out_q <= '{pc4: pc_plus4, inst: imem_data_i, valid: 1'b1};
                            pc    <= pc_plus4;
                        end
                    end else if (!Hazard_stall_i) begin
                        out_q <= BUBBLE;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        out_q <= BUBBLE;
                        pc    <= tgt;
                        state <= FETCH;
                    end else if (!Hazard_stall_i) begin
                        out_q <= '{pc4: hold_data[63:32], inst: hold_data[31:0], valid: 1'b1};
                        pc    <= pc_plus4;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect || !Hazard_stall_i) begin
                        out_q <= BUBBLE;
                    end
                    if (imem_ack_i) begin
                        pc    <= redirect ? tgt : redir_tgt;
                        state <= FETCH;
                    end else if (redirect) begin
                        redir_tgt <= tgt;
                    end
                end
                default: begin
                    out_q <= BUBBLE;
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
